risc_toy_fetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the RISC_TOY core family. It replaces the free-running PC/IREQ logic with a prefetching fetch engine. The block drives the instruction memory port (IREQ/IADDR/INSTR) and buffers fetched words with their PCs in a DEPTH-entry queue. The queue feeds decode over a valid/ready handshake. A one-cycle redirect (branch/jump resolved downstream) flushes the queue and restarts fetch.

---
 rtl/risc_toy_fetch_queue.sv | 119 +++++++++++
 tb/tb_risc_toy_fetch_queue.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/risc_toy_fetch_queue.sv
// RISC_TOY prefetching fetch engine: drives the instruction memory port,
// buffers {instruction, PC} pairs in a DEPTH-entry circular queue and hands
// them to decode over valid/ready. A one-cycle redirect flushes and restarts.
module risc_toy_fetch_queue #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                       CLK,
   input  logic                       RSTN,
   output logic                       IREQ,
   output logic [XLEN-3:0]            IADDR,
   input  logic [31:0]                INSTR,
   input  logic                       REDIR_EN,
   input  logic [XLEN-1:0]            REDIR_PC,
   output logic                       F_VALID,
   input  logic                       F_READY,
   output logic [31:0]                F_INSTR,
   output logic [XLEN-1:0]            F_PC,
   output logic [$clog2(DEPTH+1)-1:0] COUNT
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   logic [XLEN-1:0] r_fetch_pc;
   logic [XLEN-1:0] r_req_pc;
   logic            r_inflight;
   logic            r_kill;
   logic [31:0]     r_q_instr [DEPTH];
   logic [XLEN-1:0] r_q_pc    [DEPTH];
   logic [AW-1:0]   r_head;
   logic [AW-1:0]   r_tail;
   logic [CW-1:0]   r_count;

   logic            w_pop;
   logic            w_push;
   logic [CW:0]     w_space;
   logic            w_issue;
   logic [XLEN-1:0] w_redir_pc;

   // Handshake, credit and issue decisions for the current cycle
   always_comb begin
      w_pop      = (r_count != '0) & F_READY;
      w_push     = r_inflight & ~r_kill;
      // count + inflight never exceeds DEPTH, so this cannot underflow
      w_space    = DEPTH_W + {{CW{1'b0}}, w_pop}
                 - {1'b0, r_count} - {{CW{1'b0}}, r_inflight};
      // RSTN gates the request so IREQ is low while reset is held
      w_issue    = (w_space != '0) & ~REDIR_EN & RSTN;
      w_redir_pc = REDIR_PC & ~(XLEN'(3));
   end

   // Memory port and decode-side outputs; the head entry is shown directly
   always_comb begin
      IREQ    = w_issue;
      IADDR   = r_fetch_pc[XLEN-1:2];
      F_VALID = (r_count != '0);
      F_INSTR = r_q_instr[r_head];
      F_PC    = r_q_pc[r_head];
      COUNT   = r_count;
   end

   // Fetch PC, outstanding-request tracking and response kill flag
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_fetch_pc <= RESET_PC;
         r_req_pc   <= '0;
         r_inflight <= 1'b0;
         r_kill     <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         // Redirect arms kill for any request leaving this cycle; it lasts one cycle
         r_kill     <= REDIR_EN ? w_issue : 1'b0;
         if (REDIR_EN) begin
            r_fetch_pc <= w_redir_pc;
         end else if (w_issue) begin
            r_req_pc   <= r_fetch_pc;
            r_fetch_pc <= r_fetch_pc + XLEN'(4);
         end
      end
   end

   // Queue pointers and occupancy; a flush overrides any push or pop
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (REDIR_EN) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_tail <= r_tail + AW'(1);
         if (w_pop)  r_head <= r_head + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Queue storage; cleared on reset so the head outputs read zero
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_q_instr[i] <= '0;
            r_q_pc[i]    <= '0;
         end
      end else if (w_push && !REDIR_EN) begin
         r_q_instr[r_tail] <= INSTR;
         r_q_pc[r_tail]    <= r_req_pc;
      end
   end

endmodule

// File: tb/tb_risc_toy_fetch_queue.sv
// Bench for risc_toy_fetch_queue: a one-cycle memory returning its byte
// address as data, directed phases, and a scoreboard of accepted PCs.
module tb_risc_toy_fetch_queue;

   logic        CLK = 1'b0;
   logic        RSTN = 1'b1;
   logic        IREQ;
   logic [29:0] IADDR;
   logic [31:0] INSTR = 32'hDEAD_BEEF;
   logic        REDIR_EN = 1'b0;
   logic [31:0] REDIR_PC = '0;
   logic        F_VALID;
   logic        F_READY = 1'b0;
   logic [31:0] F_INSTR;
   logic [31:0] F_PC;
   logic [2:0]  COUNT;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] sb [$];
   logic [31:0] exp_pc;

   risc_toy_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
      .CLK(CLK), .RSTN(RSTN), .IREQ(IREQ), .IADDR(IADDR), .INSTR(INSTR),
      .REDIR_EN(REDIR_EN), .REDIR_PC(REDIR_PC), .F_VALID(F_VALID),
      .F_READY(F_READY), .F_INSTR(F_INSTR), .F_PC(F_PC), .COUNT(COUNT)
   );

   always #5 CLK = ~CLK;

   // memory: data = requested byte address, one cycle later; junk otherwise
   always @(posedge CLK) INSTR <= IREQ ? {IADDR, 2'b00} : 32'hDEAD_BEEF;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: every accepted head must match the next scoreboard entry
   always @(negedge CLK) begin
      if (RSTN && F_VALID && F_READY && !REDIR_EN) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_pop: got F_PC 0x%0h expected no transfer at %0t", F_PC, $time);
         end else begin
            exp_pc = sb.pop_front();
            chk("head_pc", F_PC, exp_pc);
            chk("head_instr", F_INSTR, exp_pc);
         end
      end
   end

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic neg();
      @(negedge CLK);
   endtask

   task automatic reset_and_release(input logic rdy);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      sb.delete();
      #1 RSTN = 1'b0;
      #1;
      chk("rst_ireq", 32'(IREQ), 32'd0);
      chk("rst_fvalid", 32'(F_VALID), 32'd0);
      chk("rst_finstr", F_INSTR, 32'd0);
      chk("rst_fpc", F_PC, 32'd0);
      chk("rst_count", 32'(COUNT), 32'd0);
      repeat (2) @(posedge CLK);
      #1;
      REDIR_EN = 1'b0;
      F_READY  = rdy;
      RSTN     = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      #1;
      // A: reset release, streaming at one instruction per cycle
      reset_and_release(1'b1);
      for (int i = 0; i < 4; i++) sb.push_back(32'(4 * i));
      neg();
      chk("a_c0_ireq", 32'(IREQ), 32'd1);
      chk("a_c0_iaddr", 32'(IADDR), 32'd0);
      chk("a_c0_fvalid", 32'(F_VALID), 32'd0);
      cyc(); neg();
      chk("a_c1_fvalid", 32'(F_VALID), 32'd0);
      for (int c = 2; c <= 5; c++) begin
         cyc(); neg();
         chk("a_stream_fvalid", 32'(F_VALID), 32'd1);
      end
      cyc();
      F_READY = 1'b0;

      // B: fill with F_READY low, drain, then redirect from a full queue
      reset_and_release(1'b0);
      for (int i = 0; i < 6; i++) sb.push_back(32'(4 * i));
      sb.push_back(32'h100);
      sb.push_back(32'h104);
      neg();
      chk("b_c0_ireq", 32'(IREQ), 32'd1);
      for (int c = 1; c <= 8; c++) begin
         cyc(); neg();
         chk("b_fill_ireq", 32'(IREQ), (c <= 3) ? 32'd1 : 32'd0);
         if (c >= 5) begin
            chk("b_full_count", 32'(COUNT), 32'd4);
            chk("b_hold_fpc", F_PC, 32'd0);
            chk("b_hold_finstr", F_INSTR, 32'd0);
         end
      end
      cyc();
      F_READY = 1'b1;
      neg();
      chk("b_resume_ireq", 32'(IREQ), 32'd1);
      chk("b_resume_iaddr", 32'(IADDR), 32'h4);
      chk("b_resume_count", 32'(COUNT), 32'd4);
      for (int c = 10; c <= 14; c++) begin
         cyc(); neg();
         chk("b_pushpop_count", 32'(COUNT), 32'd3);
      end
      cyc();
      F_READY = 1'b0;
      neg();
      chk("b_c15_count", 32'(COUNT), 32'd3);
      chk("b_c15_ireq", 32'(IREQ), 32'd0);
      cyc();
      REDIR_EN = 1'b1;
      REDIR_PC = 32'h100;
      neg();
      chk("b_redir_count", 32'(COUNT), 32'd4);
      chk("b_redir_ireq", 32'(IREQ), 32'd0);
      cyc();
      REDIR_EN = 1'b0;
      F_READY  = 1'b1;
      neg();
      chk("b_flush_count", 32'(COUNT), 32'd0);
      chk("b_flush_ireq", 32'(IREQ), 32'd1);
      chk("b_flush_iaddr", 32'(IADDR), 32'h40);
      chk("b_flush_fvalid", 32'(F_VALID), 32'd0);
      cyc(); neg();
      chk("b_t2_fvalid", 32'(F_VALID), 32'd0);
      cyc(); neg();
      chk("b_t3_fvalid", 32'(F_VALID), 32'd1);
      chk("b_t3_fpc", F_PC, 32'h100);
      cyc(); neg();
      cyc();
      F_READY = 1'b0;

      // C: redirect to 0x103 while the 0x20 request is in flight
      reset_and_release(1'b1);
      for (int i = 0; i < 7; i++) sb.push_back(32'(4 * i));
      sb.push_back(32'h100);
      sb.push_back(32'h104);
      neg();
      for (int c = 1; c <= 8; c++) begin
         cyc(); neg();
      end
      chk("c_req20_ireq", 32'(IREQ), 32'd1);
      chk("c_req20_iaddr", 32'(IADDR), 32'h8);
      cyc();
      REDIR_EN = 1'b1;
      REDIR_PC = 32'h103;
      neg();
      chk("c_redir_ireq", 32'(IREQ), 32'd0);
      chk("c_redir_head", F_PC, 32'h1C);
      chk("c_redir_count", 32'(COUNT), 32'd1);
      cyc();
      REDIR_EN = 1'b0;
      neg();
      chk("c_flush_count", 32'(COUNT), 32'd0);
      chk("c_flush_ireq", 32'(IREQ), 32'd1);
      chk("c_flush_iaddr", 32'(IADDR), 32'h40);
      chk("c_flush_fvalid", 32'(F_VALID), 32'd0);
      cyc(); neg();
      chk("c_t2_fvalid", 32'(F_VALID), 32'd0);
      cyc(); neg();
      chk("c_t3_fpc", F_PC, 32'h100);
      cyc(); neg();
      cyc();
      F_READY = 1'b0;

      // D: push+pop at COUNT=2 across 3*DEPTH pops, then reset at COUNT=3
      reset_and_release(1'b0);
      for (int i = 0; i < 12; i++) sb.push_back(32'(4 * i));
      neg();
      for (int c = 1; c <= 2; c++) begin
         cyc(); neg();
      end
      cyc();
      F_READY = 1'b1;
      neg();
      chk("d_pushpop_count", 32'(COUNT), 32'd2);
      for (int c = 4; c <= 14; c++) begin
         cyc(); neg();
         chk("d_pushpop_count", 32'(COUNT), 32'd2);
      end
      cyc();
      F_READY = 1'b0;
      neg();
      chk("d_c15_count", 32'(COUNT), 32'd2);
      cyc(); neg();
      chk("d_prereset_count", 32'(COUNT), 32'd3);
      reset_and_release(1'b1);
      sb.push_back(32'h0);
      sb.push_back(32'h4);
      neg();
      chk("d_restart_ireq", 32'(IREQ), 32'd1);
      chk("d_restart_iaddr", 32'(IADDR), 32'd0);
      chk("d_restart_fvalid", 32'(F_VALID), 32'd0);
      cyc(); neg();
      chk("d_c1_fvalid", 32'(F_VALID), 32'd0);
      cyc(); neg();
      chk("d_c2_fpc", F_PC, 32'd0);
      cyc(); neg();
      cyc();
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
